mio_fabric: RTL
===============

// Module: mio_fabric
// PURPOSE
//  Parametrised, handshaked successor to the CPU memory/IO address decoder.
//  Decodes one CPU data-bus request onto NSLV mask-matched slave regions
//  (RAM, VRAM, keyboard, segment, ...) or an internal local-register bank
//  (generalised cursor registers). Supports per-slave wait states, a timeout,
//  decode/timeout error reporting and a readable error-capture block.
//  Sits between the CPU memory stage and all memory-mapped peripherals.
// PARAMETERS
//  NSLV      4              number of external slave regions
//  SLV_BASE  {NSLV{32'h0}}  packed bases, slave i at [32*i+:32]
//  SLV_MASK  {NSLV{32'h0}}  packed masks; hit_i = ((addr & MASK_i) == BASE_i)
//  LOC_BASE  32'h0000_1000  base address of local register bank
//  NLOC      2              number of 32-bit local registers (1..16)
//  TIMEOUT   15             max SLAVE cycles without ready before error
//  TO_W      4              timeout counter width, 2**TO_W > TIMEOUT
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst        in   1        synchronous reset, active high
//  cpu_req    in   1        request; held stable with addr/we/wdata until ack
//  cpu_we     in   1        1 = write, 0 = read
//  cpu_addr   in   32       byte address
//  cpu_wdata  in   32       write data
//  cpu_rdata  out  32       read data, registered, valid with cpu_ack
//  cpu_ack    out  1        one-cycle completion pulse
//  cpu_err    out  1        with cpu_ack: decode error or timeout
//  slv_sel    out  NSLV     one-hot slave select, held for the whole access
//  slv_we     out  1        latched write enable
//  slv_addr   out  32       latched address
//  slv_wdata  out  32       latched write data
//  slv_rdata  in   NSLV*32  packed slave read data
//  slv_ready  in   NSLV     slave done; sampled only for the selected slave
//  loc_q      out  NLOC*32  local register contents, to peripherals
// BEHAVIOUR
//  - Reset: state IDLE; cpu_ack=0, cpu_err=0, cpu_rdata=0, slv_sel=0,
//    slv_we=0, slv_addr=0, slv_wdata=0, all loc regs=0, err_addr=0,
//    err_cnt=0, timeout counter=0. Reset mid-transaction aborts it, no ack.
//  - Decode priority: local bank, then status regs, then slave 0..NSLV-1
//    (lowest index wins on overlap). addr[1:0] ignored inside the local bank.
//  - Local map, word aligned: LOC_BASE+4k = loc reg k (k<NLOC);
//    LOC_BASE+4*NLOC = err_addr (RO); LOC_BASE+4*(NLOC+1) = {24'h0,err_cnt}
//    (any write clears it).
//  - FSM: IDLE, LOCAL, SLAVE, DECERR, RESP.
//    IDLE: cpu_req=1 -> latch we/addr/wdata, go LOCAL | SLAVE | DECERR.
//    LOCAL: perform write (takes effect at end of cycle) or capture read -> RESP.
//    SLAVE: slv_sel[i]=1; counter increments each cycle without ready;
//      ready[i]=1 -> capture slv_rdata[i] (reads), -> RESP ok;
//      counter==TIMEOUT and no ready -> RESP err; ready on the timeout cycle wins.
//    DECERR: -> RESP err.
//    RESP: cpu_ack=1 for exactly one cycle, slv_sel=0, -> IDLE.
//  - Latency: request seen in cycle n; local or zero-wait slave acks at n+2;
//    w wait cycles -> n+2+w. Timeout acks at n+2+TIMEOUT.
//  - cpu_req is ignored outside IDLE. Because of the mandatory IDLE cycle
//    after RESP, a held cpu_req starts its next access one cycle after ack.
//  - On any error: cpu_rdata=0, err_addr<=latched addr, err_cnt+1
//    saturating at 8'hFF. cpu_rdata holds its value until the next ack.
//  - Writes never change cpu_rdata. Error writes reach no slave or register.
// STRUCTURE
//  - package mio_pkg: state encoding, status offsets, err_cnt width.
//  - sub-module mio_decode: combinational addr -> {loc_hit, loc_idx,
//    stat_hit, slv_onehot}, shared with future bus masters.
// TESTING
//  - Reset during SLAVE, slv_sel=4'b0010 -> next cycle sel=0, no ack, state IDLE.
//  - Write 32'h5 to LOC_BASE, then read it -> loc_q[31:0]=5, ack at n+2,
//    cpu_rdata=5, err=0.
//  - Read slave1 with ready after 3 waits, rdata=32'hCAFE_0001 -> ack at n+5,
//    rdata=CAFE_0001.
//  - Slave never ready -> ack+err at n+17 (TIMEOUT=15), err_addr=addr,
//    err_cnt=1.
//  - Unmapped 32'hF000_0000 -> ack+err at n+2, rdata=0; then write to err_cnt
//    -> reads back 0.
//  - cpu_req held across back-to-back reads -> exactly one ack per access,
//    one IDLE cycle between; ready on an unselected slave is ignored.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU memory/IO fabric.
package mio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCAL,
    ST_SLAVE,
    ST_DECERR,
    ST_RESP
  } mio_state_e;

  // Width of the local-bank word index (covers up to 16 regs + 2 status words)
  localparam int unsigned LIDX_W   = 5;
  localparam int unsigned ERRCNT_W = 8;

  // Status word offsets, counted past the last local register
  localparam int unsigned STAT_ERR_ADDR = 0;
  localparam int unsigned STAT_ERR_CNT  = 1;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == '1) ? v : v + ERRCNT_W'(1);
  endfunction

endpackage

// File: rtl/mio_fabric_if.sv
// CPU data-bus request/response channel.
interface mio_fabric_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err
  );

endinterface

// File: rtl/mio_decode.sv
// Combinational address decoder: local bank, status words, then slaves
// in ascending index order (lowest index wins on overlap).
module mio_decode
  import mio_pkg::*;
#(
  parameter int unsigned          NSLV     = 4,
  parameter logic [32*NSLV-1:0]   SLV_BASE = {NSLV{32'h0}},
  parameter logic [32*NSLV-1:0]   SLV_MASK = {NSLV{32'h0}},
  parameter logic [31:0]          LOC_BASE = 32'h0000_1000,
  parameter int unsigned          NLOC     = 2
) (
  input  logic [31:0]       addr_i,
  output logic              loc_hit_o,
  output logic [LIDX_W-1:0] loc_idx_o,
  output logic              stat_hit_o,
  output logic [NSLV-1:0]   slv_onehot_o
);

  logic [29:0] woff;
  logic        found;

  // Word offset into the local bank decides register vs status vs external
  always_comb begin
    woff         = addr_i[31:2] - LOC_BASE[31:2];
    loc_hit_o    = (woff < 30'(NLOC));
    stat_hit_o   = !loc_hit_o && (woff < 30'(NLOC + 2));
    loc_idx_o    = woff[LIDX_W-1:0];
    slv_onehot_o = '0;
    found        = 1'b0;
    if (!loc_hit_o && !stat_hit_o) begin
      for (int unsigned i = 0; i < NSLV; i++) begin
        if (!found && ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
          slv_onehot_o[i] = 1'b1;
          found           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mio_fabric.sv
// Handshaked CPU memory/IO fabric: decodes one request onto a local
// register bank, status words or one of NSLV external slaves, with wait
// states, timeout and error capture.
module mio_fabric
  import mio_pkg::*;
#(
  parameter int unsigned          NSLV     = 4,
  parameter logic [32*NSLV-1:0]   SLV_BASE = {NSLV{32'h0}},
  parameter logic [32*NSLV-1:0]   SLV_MASK = {NSLV{32'h0}},
  parameter logic [31:0]          LOC_BASE = 32'h0000_1000,
  parameter int unsigned          NLOC     = 2,
  parameter int unsigned          TIMEOUT  = 15,
  parameter int unsigned          TO_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mio_fabric_if.slave          cpu,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  input  logic [NSLV*32-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ready,
  output logic [NLOC*32-1:0]   loc_q
);

  mio_state_e          state_q;
  logic                ack_q, err_q;
  logic [31:0]         rdata_q;
  logic [NSLV-1:0]     sel_q;
  logic                we_q;
  logic [31:0]         addr_q, wdata_q;
  logic [31:0]         loc_regs_q [NLOC];
  logic [31:0]         err_addr_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic [TO_W-1:0]     to_q;
  logic [LIDX_W-1:0]   idx_q;
  logic                stat_q;

  logic                dec_loc_hit, dec_stat_hit;
  logic [LIDX_W-1:0]   dec_idx;
  logic [NSLV-1:0]     dec_onehot;
  logic [31:0]         sel_rdata, loc_rdata;
  logic                sel_ready;

  mio_decode #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .LOC_BASE (LOC_BASE),
    .NLOC     (NLOC)
  ) u_decode (
    .addr_i       (cpu.cpu_addr),
    .loc_hit_o    (dec_loc_hit),
    .loc_idx_o    (dec_idx),
    .stat_hit_o   (dec_stat_hit),
    .slv_onehot_o (dec_onehot)
  );

  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_err   = err_q;
  assign cpu.cpu_rdata = rdata_q;
  assign slv_sel       = sel_q;
  assign slv_we        = we_q;
  assign slv_addr      = addr_q;
  assign slv_wdata     = wdata_q;

  for (genvar k = 0; k < NLOC; k++) begin : g_loc
    assign loc_q[32*k +: 32] = loc_regs_q[k];
  end

  // Read-data muxes for the selected slave and the addressed local word
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (sel_q[i]) sel_rdata |= slv_rdata[32*i +: 32];
    end
    sel_ready = |(slv_ready & sel_q);
    loc_rdata = '0;
    if (stat_q) begin
      loc_rdata = (idx_q == LIDX_W'(NLOC + STAT_ERR_ADDR)) ? err_addr_q
                : {{(32-ERRCNT_W){1'b0}}, err_cnt_q};
    end else begin
      for (int unsigned k = 0; k < NLOC; k++) begin
        if (idx_q == LIDX_W'(k)) loc_rdata = loc_regs_q[k];
      end
    end
  end

  // Access sequencer; all CPU and slave-side outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      loc_regs_q <= '{default: '0};
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      to_q       <= '0;
      idx_q      <= '0;
      stat_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu.cpu_req) begin
            we_q    <= cpu.cpu_we;
            addr_q  <= cpu.cpu_addr;
            wdata_q <= cpu.cpu_wdata;
            idx_q   <= dec_idx;
            stat_q  <= dec_stat_hit;
            to_q    <= '0;
            if (dec_loc_hit || dec_stat_hit) begin
              state_q <= ST_LOCAL;
            end else if (|dec_onehot) begin
              sel_q   <= dec_onehot;
              state_q <= ST_SLAVE;
            end else begin
              state_q <= ST_DECERR;
            end
          end
        end
        ST_LOCAL: begin
          if (we_q) begin
            if (stat_q) begin
              if (idx_q == LIDX_W'(NLOC + STAT_ERR_CNT)) err_cnt_q <= '0;
            end else begin
              for (int unsigned k = 0; k < NLOC; k++) begin
                if (idx_q == LIDX_W'(k)) loc_regs_q[k] <= wdata_q;
              end
            end
          end else begin
            rdata_q <= loc_rdata;
          end
          ack_q   <= 1'b1;
          err_q   <= 1'b0;
          state_q <= ST_RESP;
        end
        ST_SLAVE: begin
          // Ready takes precedence over an expiring timeout in the same cycle
          if (sel_ready) begin
            if (!we_q) rdata_q <= sel_rdata;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            sel_q   <= '0;
            state_q <= ST_RESP;
          end else if (to_q == TO_W'(TIMEOUT)) begin
            ack_q      <= 1'b1;
            err_q      <= 1'b1;
            rdata_q    <= '0;
            err_addr_q <= addr_q;
            err_cnt_q  <= sat_inc(err_cnt_q);
            sel_q      <= '0;
            state_q    <= ST_RESP;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        ST_DECERR: begin
          ack_q      <= 1'b1;
          err_q      <= 1'b1;
          rdata_q    <= '0;
          err_addr_q <= addr_q;
          err_cnt_q  <= sat_inc(err_cnt_q);
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
